// File: rtl/s1488_scan_driver.sv
// Serial-in pattern driver for s1488 next-state slices: shift a pattern in, apply it, settle, capture and return the response.
// Optional even-parity check on each pattern is enabled by defining S1488_DRV_PARITY_EN.
module s1488_scan_driver #(
  parameter int PAT_W  = 14,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si_valid,
  input  logic             si_data,
  output logic             si_ready,
  output logic [PAT_W-1:0] pat_out,
  input  logic             slice_resp,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_data,
  output logic [PAT_W-1:0] res_pat,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_WAIT, ST_RESP} state_t;

`ifdef S1488_DRV_PARITY_EN
  localparam int NBITS = PAT_W + 1;
`else
  localparam int NBITS = PAT_W;
`endif

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   sh_q, sh_d;
  logic [PAT_W-1:0]   pat_out_q, pat_out_d;
  logic [PAT_W-1:0]   res_pat_q, res_pat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   settle_q, settle_d;
  logic               res_valid_q, res_valid_d;
  logic               res_data_q, res_data_d;
  logic               err_q, err_d;

  logic [PAT_W-1:0]   shifted;
  logic [PAT_W-1:0]   full_pat;
  logic [CNT_W-1:0]   cnt_cur;
  logic               accept;
  logic               last_bit;
  logic               shift_en;
  logic               par_ok;

  // New bits enter at the MSB so that after PAT_W shifts bit i is the i-th bit sent.
  generate
    if (PAT_W == 1) begin : g_sh1
      assign shifted = si_data;
    end else begin : g_shn
      assign shifted = {si_data, sh_q[PAT_W-1:1]};
    end
  endgenerate

  assign si_ready = (state_q == ST_IDLE) || (state_q == ST_SHIFT);
  assign accept   = si_valid && si_ready;
  assign cnt_cur  = (state_q == ST_IDLE) ? '0 : cnt_q;
  assign last_bit = (cnt_cur == CNT_W'(NBITS - 1));
  assign shift_en = (cnt_cur < CNT_W'(PAT_W));

`ifdef S1488_DRV_PARITY_EN
  // The trailing bit is the parity bit; the data is already complete in the shift register.
  assign full_pat = sh_q;
  assign par_ok   = (^sh_q) == si_data;
`else
  assign full_pat = shifted;
  assign par_ok   = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    pat_out_d   = pat_out_q;
    res_pat_d   = res_pat_q;
    cnt_d       = cnt_q;
    settle_d    = settle_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE, ST_SHIFT: begin
        if (accept) begin
          if (shift_en) sh_d = shifted;
          cnt_d = cnt_cur + 1'b1;
          if (last_bit) begin
            cnt_d = '0;
            if (par_ok) begin
              pat_out_d = full_pat;
              settle_d  = CNT_W'(SETTLE);
              state_d   = ST_WAIT;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_WAIT: begin
        settle_d = settle_q - 1'b1;
        if (settle_q <= CNT_W'(1)) begin
          settle_d    = '0;
          res_data_d  = slice_resp;
          res_pat_d   = pat_out_q;
          res_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sh_q        <= '0;
      pat_out_q   <= '0;
      res_pat_q   <= '0;
      cnt_q       <= '0;
      settle_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      pat_out_q   <= pat_out_d;
      res_pat_q   <= res_pat_d;
      cnt_q       <= cnt_d;
      settle_q    <= settle_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      err_q       <= err_d;
    end
  end

  assign pat_out   = pat_out_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_pat   = res_pat_q;
  assign busy      = (state_q != ST_IDLE);

`ifdef S1488_DRV_PARITY_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_s1488_scan_driver.sv
// Directed bench for s1488_scan_driver with the CLR & ~v7 slice stub on the response input.
module tb_s1488_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        si_valid = 1'b0;
  logic        si_data = 1'b0;
  logic        si_ready;
  logic [13:0] pat_out;
  logic        slice_resp;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic        res_data;
  logic [13:0] res_pat;
  logic        busy;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign slice_resp = pat_out[0] & ~pat_out[8];

  s1488_scan_driver #(.PAT_W(14), .SETTLE(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .si_valid(si_valid), .si_data(si_data), .si_ready(si_ready),
    .pat_out(pat_out), .slice_resp(slice_resp),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_pat(res_pat),
    .busy(busy), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends 14 data bits LSB first (plus a parity bit when the option is built in),
  // returning right after the edge that accepts the final bit.
  task automatic send_pat(input logic [13:0] pat, input bit gaps, input bit par_flip);
    for (int i = 0; i < 14; i++) begin
      if (gaps && i > 0) begin
        si_valid = 1'b0;
        tick();
      end
      si_valid = 1'b1;
      si_data  = pat[i];
      tick();
    end
`ifdef S1488_DRV_PARITY_EN
    if (gaps) begin
      si_valid = 1'b0;
      tick();
    end
    si_valid = 1'b1;
    si_data  = (^pat) ^ par_flip;
    tick();
`else
    if (par_flip) $display("note: parity flip ignored, option not built");
`endif
    si_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    total += 5;
    if (pat_out !== 14'h0000) begin bad++; $display("FAIL reset_pat_out got=%h exp=0000", pat_out); end
    if (res_valid !== 1'b0)   begin bad++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    if (si_ready !== 1'b1)    begin bad++; $display("FAIL reset_si_ready got=%b exp=1", si_ready); end
    if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (err !== 1'b0)         begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    $display("test_reset: pat_out=%h res_valid=%b si_ready=%b busy=%b", pat_out, res_valid, si_ready, busy);
  endtask

  task automatic test_basic(input logic [13:0] pat, input logic exp_data);
    res_ready = 1'b1;
    send_pat(pat, 1'b0, 1'b0);
    total += 3;
    if (pat_out !== pat)    begin bad++; $display("FAIL basic_pat_out_t got=%h exp=%h", pat_out, pat); end
    if (res_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_t got=%b exp=0", res_valid); end
    if (si_ready !== 1'b0)  begin bad++; $display("FAIL basic_si_ready_t got=%b exp=0", si_ready); end
    tick();
    total += 3;
    if (res_valid !== 1'b1)     begin bad++; $display("FAIL basic_valid_t1 got=%b exp=1", res_valid); end
    if (res_data !== exp_data)  begin bad++; $display("FAIL basic_data got=%b exp=%b", res_data, exp_data); end
    if (res_pat !== pat)        begin bad++; $display("FAIL basic_res_pat got=%h exp=%h", res_pat, pat); end
    tick();
    total += 3;
    if (busy !== 1'b0)      begin bad++; $display("FAIL basic_idle_busy got=%b exp=0", busy); end
    if (res_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_t2 got=%b exp=0", res_valid); end
    if (pat_out !== pat)    begin bad++; $display("FAIL basic_pat_hold got=%h exp=%h", pat_out, pat); end
    $display("test_basic: pat=%h res_data=%b res_pat=%h", pat, res_data, res_pat);
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    send_pat(14'h0001, 1'b0, 1'b0);
    tick();
    si_valid = 1'b1;
    si_data  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      total += 5;
      if (res_valid !== 1'b1)     begin bad++; $display("FAIL bp_valid c=%0d got=%b exp=1", c, res_valid); end
      if (res_data !== 1'b1)      begin bad++; $display("FAIL bp_data c=%0d got=%b exp=1", c, res_data); end
      if (res_pat !== 14'h0001)   begin bad++; $display("FAIL bp_res_pat c=%0d got=%h exp=0001", c, res_pat); end
      if (si_ready !== 1'b0)      begin bad++; $display("FAIL bp_si_ready c=%0d got=%b exp=0", c, si_ready); end
      if (pat_out !== 14'h0001)   begin bad++; $display("FAIL bp_pat_out c=%0d got=%h exp=0001", c, pat_out); end
      tick();
    end
    si_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    total += 3;
    if (busy !== 1'b0)      begin bad++; $display("FAIL bp_idle got=%b exp=0", busy); end
    if (res_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_drop got=%b exp=0", res_valid); end
    if (si_ready !== 1'b1)  begin bad++; $display("FAIL bp_si_ready_back got=%b exp=1", si_ready); end
    $display("test_backpressure: held 5 cycles, busy=%b si_ready=%b", busy, si_ready);
  endtask

  task automatic test_gaps_reset();
    for (int i = 0; i < 7; i++) begin
      si_valid = 1'b1;
      si_data  = 1'b1;
      tick();
    end
    si_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total += 2;
    if (busy !== 1'b0)        begin bad++; $display("FAIL gr_rst_busy got=%b exp=0", busy); end
    if (pat_out !== 14'h0000) begin bad++; $display("FAIL gr_rst_pat got=%h exp=0000", pat_out); end
    send_pat(14'h0001, 1'b1, 1'b0);
    total += 1;
    if (pat_out !== 14'h0001) begin bad++; $display("FAIL gr_pat_out got=%h exp=0001", pat_out); end
    tick();
    total += 3;
    if (res_valid !== 1'b1)   begin bad++; $display("FAIL gr_valid got=%b exp=1", res_valid); end
    if (res_data !== 1'b1)    begin bad++; $display("FAIL gr_data got=%b exp=1", res_data); end
    if (res_pat !== 14'h0001) begin bad++; $display("FAIL gr_res_pat got=%h exp=0001", res_pat); end
    tick();
    $display("test_gaps_reset: res_pat=%h res_data=%b", res_pat, res_data);
  endtask

`ifdef S1488_DRV_PARITY_EN
  task automatic test_parity();
    logic [13:0] prev;
    prev = pat_out;
    send_pat(14'h0001, 1'b0, 1'b1);
    total += 4;
    if (err !== 1'b1)       begin bad++; $display("FAIL par_err got=%b exp=1", err); end
    if (pat_out !== prev)   begin bad++; $display("FAIL par_pat_out got=%h exp=%h", pat_out, prev); end
    if (busy !== 1'b0)      begin bad++; $display("FAIL par_busy got=%b exp=0", busy); end
    if (res_valid !== 1'b0) begin bad++; $display("FAIL par_valid got=%b exp=0", res_valid); end
    tick();
    total += 2;
    if (err !== 1'b0)       begin bad++; $display("FAIL par_err_pulse got=%b exp=0", err); end
    if (res_valid !== 1'b0) begin bad++; $display("FAIL par_valid2 got=%b exp=0", res_valid); end
    $display("test_parity: bad parity rejected, pat_out=%h", pat_out);
  endtask
`endif

  initial begin
    test_reset();
`ifdef S1488_DRV_PARITY_EN
    test_basic(14'h0100, 1'b0);
    test_parity();
`endif
    test_basic(14'h0001, 1'b1);
    test_basic(14'h0101, 1'b0);
    test_basic(14'h0100, 1'b0);
    test_basic(14'h2AAB, 1'b1);
    test_basic(14'h3FFF, 1'b0);
    test_backpressure();
    test_gaps_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
